sysarray_mm: RTL and testbench

- Parametrised output-stationary N x N systolic matrix multiplier; successor to the fixed 3x3, 32-bit array.
- Computes C = A x B in three steps:
  - streams A column-wise and B row-wise over K = N beats with a valid/ready handshake;
  - skews operands internally;
  - drains C one row per cycle under output backpressure.
- Adds a signed mode and an accumulate mode (C += A x B) for K-tiling.
- Sits between the operand buffers and the result writeback path.

---
 rtl/sysarray_mm.sv | 257 +++++++++++++++++++++++++
 tb/tb_sysarray_mm.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysarray_mm.sv
// sysarray_mm: output-stationary N x N systolic matrix multiplier.
// A arrives column-wise and B row-wise over N beats; each row of A and each
// column of B is skewed so that A[i][k] and B[k][j] meet in PE(i,j) in the
// same cycle. Every PE accumulates its C element locally, and the rows of C
// are then drained one per cycle through a registered output stage.
module sysarray_mm #(
  parameter int DW     = 32,
  parameter int N      = 3,
  parameter int AW     = 2*DW + $clog2(N) + 1,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 accumulate,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DW-1:0]      a_col,
  input  logic [N*DW-1:0]      b_row,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*AW-1:0]      out_row,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 done
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(2*N);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   k_q, k_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic            done_q, done_d;
  logic [N*AW-1:0] out_row_q, out_row_d;
  logic [IW-1:0]   out_idx_q, out_idx_d;
  logic            clear_acc;
  logic            beat;

  logic [DW-1:0]   a_edge [N];
  logic [DW-1:0]   b_edge [N];
  logic [DW-1:0]   a_skew [N];
  logic [DW-1:0]   b_skew [N];
  logic [DW-1:0]   a_in_w [N][N];
  logic [DW-1:0]   b_in_w [N][N];
  logic [AW-1:0]   acc_all [N*N];

  // in_ready is a registered copy of "state is LOAD", so it qualifies beats directly
  assign beat = in_valid & in_ready_q;

  // Control: state sequencing, beat/compute counters and the drain output stage
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_idx_d   = out_idx_q;
    done_d      = 1'b0;
    clear_acc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          k_d       = '0;
          clear_acc = ~accumulate;
        end
      end
      S_LOAD: begin
        if (beat) begin
          if (k_q == IW'(N-1)) begin
            state_d = S_COMPUTE;
            cnt_d   = '0;
          end else begin
            k_d = k_q + IW'(1);
          end
        end
      end
      S_COMPUTE: begin
        // The last product reaches PE(N-1,N-1) 2N-2 edges after the last beat
        if (cnt_q == CW'(2*N-2)) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (!out_valid_q) begin
          // First DRAIN cycle: present row 0
          out_valid_d = 1'b1;
          out_idx_d   = '0;
          for (int j = 0; j < N; j++) begin
            out_row_d[j*AW +: AW] = acc_all[j];
          end
        end else if (out_ready) begin
          if (out_idx_q == IW'(N-1)) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end else begin
            out_idx_d = out_idx_q + IW'(1);
            for (int j = 0; j < N; j++) begin
              out_row_d[j*AW +: AW] = acc_all[(int'(out_idx_q) + 1) * N + j];
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d     = (state_d != S_IDLE);
    in_ready_d = (state_d == S_LOAD);
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_row_q   <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      out_row_q   <= out_row_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign out_row   = out_row_q;
  assign out_idx   = out_idx_q;

  // Input skew: row gi of A and column gi of B are delayed by gi cycles.
  // Cycles without an accepted beat inject zeros, so bubbles add nothing.
  for (genvar gi = 0; gi < N; gi++) begin : g_edge
    assign a_edge[gi] = beat ? a_col[gi*DW +: DW] : '0;
    assign b_edge[gi] = beat ? b_row[gi*DW +: DW] : '0;
    if (gi == 0) begin : g_nodly
      assign a_skew[gi] = a_edge[gi];
      assign b_skew[gi] = b_edge[gi];
    end else begin : g_dly
      logic [DW-1:0] a_dly_q [gi];
      logic [DW-1:0] a_dly_d [gi];
      logic [DW-1:0] b_dly_q [gi];
      logic [DW-1:0] b_dly_d [gi];

      // Shift the edge value one stage further along the delay line
      always_comb begin
        a_dly_d[0] = a_edge[gi];
        b_dly_d[0] = b_edge[gi];
        for (int t = 1; t < gi; t++) begin
          a_dly_d[t] = a_dly_q[t-1];
          b_dly_d[t] = b_dly_q[t-1];
        end
      end

      // Delay-line registers
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int t = 0; t < gi; t++) begin
            a_dly_q[t] <= '0;
            b_dly_q[t] <= '0;
          end
        end else begin
          a_dly_q <= a_dly_d;
          b_dly_q <= b_dly_d;
        end
      end

      assign a_skew[gi] = a_dly_q[gi-1];
      assign b_skew[gi] = b_dly_q[gi-1];
    end
  end

  // PE grid: a flows right, b flows down, each PE keeps one C element
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [2*DW-1:0] prod;
      logic [AW-1:0]   prod_ext;
      logic [AW-1:0]   acc_q, acc_d;

      if (gj == 0) begin : g_a_src
        assign a_in_w[gi][gj] = a_skew[gi];
      end
      if (gi == 0) begin : g_b_src
        assign b_in_w[gi][gj] = b_skew[gj];
      end

      if (gj < N-1) begin : g_a_fwd
        logic [DW-1:0] a_q, a_d;
        // Operand forwarded to the right neighbour
        always_comb a_d = a_in_w[gi][gj];
        // Forwarding register for a
        always_ff @(posedge clk) begin
          if (rst) a_q <= '0;
          else     a_q <= a_d;
        end
        assign a_in_w[gi][gj+1] = a_q;
      end

      if (gi < N-1) begin : g_b_fwd
        logic [DW-1:0] b_q, b_d;
        // Operand forwarded to the neighbour below
        always_comb b_d = b_in_w[gi][gj];
        // Forwarding register for b
        always_ff @(posedge clk) begin
          if (rst) b_q <= '0;
          else     b_q <= b_d;
        end
        assign b_in_w[gi+1][gj] = b_q;
      end

      // Full-width product; the low 2*DW bits are exact in both modes
      if (SIGNED != 0) begin : g_smul
        assign prod = $signed({{DW{a_in_w[gi][gj][DW-1]}}, a_in_w[gi][gj]})
                    * $signed({{DW{b_in_w[gi][gj][DW-1]}}, b_in_w[gi][gj]});
      end else begin : g_umul
        assign prod = {{DW{1'b0}}, a_in_w[gi][gj]} * {{DW{1'b0}}, b_in_w[gi][gj]};
      end

      if (AW > 2*DW) begin : g_ext
        assign prod_ext = {{(AW-2*DW){(SIGNED != 0) & prod[2*DW-1]}}, prod};
      end else begin : g_trunc
        assign prod_ext = prod[AW-1:0];
      end

      // Multiply-accumulate, wrapping modulo 2^AW; cleared by a non-accumulating start
      always_comb acc_d = clear_acc ? '0 : acc_q + prod_ext;

      // Accumulator register
      always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
      end

      assign acc_all[gi*N + gj] = acc_q;
    end
  end

endmodule

// File: tb/tb_sysarray_mm.sv
// tb_sysarray_mm: scoreboard bench for sysarray_mm (N=3, DW=32).
// Two instances: u_dut0 unsigned, u_dut1 signed. Expected rows come from a
// bench-side matrix model and are queued when the operands are driven.
`timescale 1ns/1ps
module tb_sysarray_mm;
  localparam int DW = 32;
  localparam int N  = 3;
  localparam int AW = 2*DW + $clog2(N) + 1;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start0 = 1'b0, start1 = 1'b0;
  logic            accumulate = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [N*DW-1:0] a_col = '0, b_row = '0;

  logic            in_ready0, busy0, out_valid0, done0;
  logic [N*AW-1:0] out_row0;
  logic [IW-1:0]   out_idx0;
  logic            in_ready1, busy1, out_valid1, done1;
  logic [N*AW-1:0] out_row1;
  logic [IW-1:0]   out_idx1;

  sysarray_mm #(.DW(DW), .N(N), .AW(AW), .SIGNED(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .accumulate(accumulate),
    .in_valid(in_valid), .in_ready(in_ready0), .a_col(a_col), .b_row(b_row),
    .busy(busy0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_row(out_row0), .out_idx(out_idx0), .done(done0)
  );

  sysarray_mm #(.DW(DW), .N(N), .AW(AW), .SIGNED(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .accumulate(accumulate),
    .in_valid(in_valid), .in_ready(in_ready1), .a_col(a_col), .b_row(b_row),
    .busy(busy1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_row(out_row1), .out_idx(out_idx1), .done(done1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [N*AW-1:0] row;
    logic [IW-1:0]   idx;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  logic [AW-1:0] mdl [2][N][N];
  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];

  int first0 = -1, done_cyc0 = -1, done_cnt0 = 0;
  int first1 = -1, done_cyc1 = -1, done_cnt1 = 0;

  function automatic logic [N*AW-1:0] mrow(input int w, input int r);
    logic [N*AW-1:0] v;
    for (int j = 0; j < N; j++) v[j*AW +: AW] = mdl[w][r][j];
    return v;
  endfunction

  // Monitor / scoreboard for the unsigned instance
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (out_valid0 && first0 < 0) first0 = cyc;
      if (done0) begin done_cnt0++; done_cyc0 = cyc; end
      if (out_valid0 && out_ready) begin
        checks++;
        if (q0.size() == 0) begin
          $display("FAIL dut0_unexpected_row idx=%0d row=%h expected=none", out_idx0, out_row0);
        end else begin
          e0 = q0.pop_front();
          if (out_row0 !== e0.row || out_idx0 !== e0.idx)
            $display("FAIL dut0_row idx=%0d row=%h expected idx=%0d row=%h", out_idx0, out_row0, e0.idx, e0.row);
          else begin
            passes++;
            $display("dut0 row %0d = %h (cycle %0d)", out_idx0, out_row0, cyc);
          end
        end
      end
    end
  end

  // Monitor / scoreboard for the signed instance
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (out_valid1 && first1 < 0) first1 = cyc;
      if (done1) begin done_cnt1++; done_cyc1 = cyc; end
      if (out_valid1 && out_ready) begin
        checks++;
        if (q1.size() == 0) begin
          $display("FAIL dut1_unexpected_row idx=%0d row=%h expected=none", out_idx1, out_row1);
        end else begin
          e1 = q1.pop_front();
          if (out_row1 !== e1.row || out_idx1 !== e1.idx)
            $display("FAIL dut1_row idx=%0d row=%h expected idx=%0d row=%h", out_idx1, out_row1, e1.idx, e1.row);
          else begin
            passes++;
            $display("dut1 row %0d = %h (cycle %0d)", out_idx1, out_row1, cyc);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_mats(input logic neg_identity_a);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mb[i][j] = DW'(3*i + j + 1);
        if (neg_identity_a) ma[i][j] = (i == j) ? {DW{1'b1}} : '0;
        else                ma[i][j] = DW'(3*i + j + 1);
      end
  endtask

  task automatic clear_stats();
    first0 = -1; done_cyc0 = -1; done_cnt0 = 0;
    first1 = -1; done_cyc1 = -1; done_cnt1 = 0;
  endtask

  // Start one operation, update the model, queue the expected rows, drive N beats
  task automatic do_op(input int which, input logic accum, input int bubble, output int c0);
    logic signed [AW-1:0] sa, sb;
    logic [AW-1:0] p;
    exp_t e;
    @(posedge clk); #1;
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    accumulate = accum;
    c0 = cyc;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (!accum) mdl[which][i][j] = '0;
        for (int k = 0; k < N; k++) begin
          if (which == 1) begin
            sa = $signed(ma[i][k]);
            sb = $signed(mb[k][j]);
            p  = sa * sb;
          end else begin
            p = {{(AW-DW){1'b0}}, ma[i][k]} * {{(AW-DW){1'b0}}, mb[k][j]};
          end
          mdl[which][i][j] = mdl[which][i][j] + p;
        end
      end
    for (int r = 0; r < N; r++) begin
      e.row = mrow(which, r);
      e.idx = IW'(r);
      if (which == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0; accumulate = 1'b0;
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = ma[i][k];
        b_row[i*DW +: DW] = mb[k][i];
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = $urandom;
        b_row[i*DW +: DW] = $urandom;
      end
      if (k == 0) for (int b = 0; b < bubble; b++) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready0 !== 1'b0) $display("FAIL reset_in_ready got=%b expected=0", in_ready0); else passes++;
    checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy got=%b expected=0", busy0); else passes++;
    checks++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid got=%b expected=0", out_valid0); else passes++;
    checks++; if (done0 !== 1'b0) $display("FAIL reset_done got=%b expected=0", done0); else passes++;
    checks++; if (out_row0 !== '0) $display("FAIL reset_out_row got=%h expected=0", out_row0); else passes++;
    checks++; if (out_idx0 !== '0) $display("FAIL reset_out_idx got=%0d expected=0", out_idx0); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    // Beats offered while IDLE must be ignored
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b0 || busy0 !== 1'b0)
      $display("FAIL idle_ignores_beats in_ready=%b busy=%b expected 0/0", in_ready0, busy0);
    else passes++;
    $display("test_reset: checks=%0d passes=%0d", checks, passes);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done0(input string name);
    for (int t = 0; t < 100 && done_cnt0 == 0; t++) @(negedge clk);
    checks++;
    if (done_cnt0 == 0) $display("FAIL %s_timeout done_cnt=%0d expected=1", name, done_cnt0);
    else passes++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    int c0;
    clear_stats();
    set_mats(1'b0);
    do_op(0, 1'b0, 0, c0);
    // start while busy must be ignored
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_done0("basic");
    checks++; if (first0 !== c0 + 10) $display("FAIL basic_first_valid got=%0d expected=%0d", first0 - c0, 10); else passes++;
    checks++; if (done_cyc0 !== c0 + 13) $display("FAIL basic_done_cycle got=%0d expected=%0d", done_cyc0 - c0, 13); else passes++;
    checks++; if (done_cnt0 !== 1) $display("FAIL basic_done_count got=%0d expected=1", done_cnt0); else passes++;
    checks++; if (q0.size() !== 0) $display("FAIL basic_rows_left got=%0d expected=0", q0.size()); else passes++;
    checks++; if (busy0 !== 1'b0) $display("FAIL basic_busy_after got=%b expected=0", busy0); else passes++;
  endtask

  task automatic test_accumulate();
    int c0;
    clear_stats();
    do_op(0, 1'b1, 0, c0);
    wait_done0("accumulate");
    checks++; if (done_cnt0 !== 1) $display("FAIL accum_done_count got=%0d expected=1", done_cnt0); else passes++;
    checks++; if (q0.size() !== 0) $display("FAIL accum_rows_left got=%0d expected=0", q0.size()); else passes++;
  endtask

  task automatic test_bubble();
    int c0;
    clear_stats();
    do_op(0, 1'b0, 2, c0);
    wait_done0("bubble");
    checks++; if (first0 !== c0 + 12) $display("FAIL bubble_first_valid got=%0d expected=%0d", first0 - c0, 12); else passes++;
    checks++; if (done_cyc0 !== c0 + 15) $display("FAIL bubble_done_cycle got=%0d expected=%0d", done_cyc0 - c0, 15); else passes++;
    checks++; if (q0.size() !== 0) $display("FAIL bubble_rows_left got=%0d expected=0", q0.size()); else passes++;
  endtask

  task automatic test_backpressure();
    int c0;
    logic [N*AW-1:0] r1;
    clear_stats();
    do_op(0, 1'b0, 0, c0);
    r1 = mrow(0, 1);
    while (cyc < c0 + 11) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checks++;
      if (out_valid0 !== 1'b1 || out_idx0 !== IW'(1) || out_row0 !== r1)
        $display("FAIL stall_hold_%0d valid=%b idx=%0d row=%h expected valid=1 idx=1 row=%h",
                 s, out_valid0, out_idx0, out_row0, r1);
      else passes++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done0("backpressure");
    checks++; if (done_cyc0 !== c0 + 16) $display("FAIL stall_done_cycle got=%0d expected=%0d", done_cyc0 - c0, 16); else passes++;
    checks++; if (done_cnt0 !== 1) $display("FAIL stall_done_count got=%0d expected=1", done_cnt0); else passes++;
    checks++; if (q0.size() !== 0) $display("FAIL stall_rows_left got=%0d expected=0", q0.size()); else passes++;
  endtask

  task automatic test_signed();
    int c0;
    clear_stats();
    set_mats(1'b1);
    do_op(1, 1'b0, 0, c0);
    for (int t = 0; t < 100 && done_cnt1 == 0; t++) @(negedge clk);
    checks++;
    if (done_cnt1 == 0) $display("FAIL signed_timeout done_cnt=%0d expected=1", done_cnt1); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (first1 !== c0 + 10) $display("FAIL signed_first_valid got=%0d expected=%0d", first1 - c0, 10); else passes++;
    checks++; if (done_cyc1 !== c0 + 13) $display("FAIL signed_done_cycle got=%0d expected=%0d", done_cyc1 - c0, 13); else passes++;
    checks++; if (q1.size() !== 0) $display("FAIL signed_rows_left got=%0d expected=0", q1.size()); else passes++;
    checks++; if (done_cnt0 !== 0) $display("FAIL signed_dut0_idle got=%0d expected=0", done_cnt0); else passes++;
  endtask

  task automatic test_reset_midload();
    int c0;
    clear_stats();
    set_mats(1'b0);
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = ma[i][k];
        b_row[i*DW +: DW] = mb[k][i];
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) mdl[w][i][j] = '0;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || in_ready0 !== 1'b0 || out_valid0 !== 1'b0 || done0 !== 1'b0 ||
        out_row0 !== '0 || out_idx0 !== '0)
      $display("FAIL midload_reset busy=%b in_ready=%b out_valid=%b done=%b idx=%0d row=%h expected all 0",
               busy0, in_ready0, out_valid0, done0, out_idx0, out_row0);
    else passes++;
    // accumulate=1: any residue left by the aborted run would show in the result
    do_op(0, 1'b1, 0, c0);
    wait_done0("midload");
    checks++; if (first0 !== c0 + 10) $display("FAIL midload_first_valid got=%0d expected=%0d", first0 - c0, 10); else passes++;
    checks++; if (q0.size() !== 0) $display("FAIL midload_rows_left got=%0d expected=0", q0.size()); else passes++;
  endtask

  initial begin
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) mdl[w][i][j] = '0;
    test_reset();
    test_basic();
    test_accumulate();
    test_bubble();
    test_backpressure();
    test_signed();
    test_reset_midload();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
